// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS stream generator.
package prbs_pkg;

  // Widest LFSR the shared step function supports
  localparam int unsigned LFSR_MAX_W = 32;

  // Default 8-bit Galois feedback mask (x^8 + x^6 + x^5 + x^4 + 1)
  localparam logic [7:0] PRBS_DEFAULT_POLY = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2
  } prbs_state_e;

  // One Galois step: emits state[0] and returns the next state.
  // Narrower LFSRs pass zero-extended state/poly; upper bits stay zero.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input  logic [LFSR_MAX_W-1:0] state,
    input  logic [LFSR_MAX_W-1:0] poly,
    output logic                  bit_out
  );
    bit_out   = state[0];
    lfsr_step = (state >> 1) ^ (state[0] ? poly : '0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO with registered head and valid.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         pop_data,
  output logic                          valid,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [LVL_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic                  valid_q;

  logic                  do_push;
  logic                  do_pop;
  logic [LVL_W-1:0]      count_d;
  logic [PTR_W-1:0]      rd_ptr_d;
  logic                  head_from_input;

  assign full     = (count_q == LVL_W'(FIFO_DEPTH));
  assign do_pop   = pop && valid_q;
  assign do_push  = push && (!full || do_pop);

  // Next occupancy / read pointer and whether the incoming word becomes the head
  always_comb begin
    count_d         = count_q + LVL_W'(do_push) - LVL_W'(do_pop);
    rd_ptr_d        = rd_ptr_q + PTR_W'(do_pop);
    head_from_input = do_push && (count_q == LVL_W'(do_pop));
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointers, occupancy and the registered FWFT head
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_q + PTR_W'(do_push);
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      if (head_from_input) begin
        head_q <= push_data;
      end else if (do_pop && (count_d != '0)) begin
        head_q <= mem[rd_ptr_d];
      end
    end
  end

  assign pop_data = head_q;
  assign valid    = valid_q;
  assign empty    = !valid_q;
  assign level    = count_q;

endmodule

// File: rtl/prbs_stream_gen.sv
// PRBS word source: Galois LFSR -> LSB-first packer -> FWFT FIFO stream.
// Optional build macro PRBS_STREAM_ERR_INJECT_EN adds the err_inject port,
// which flips bit 0 of the next word written to the FIFO.
// LFSR_WIDTH is limited to prbs_pkg::LFSR_MAX_W.
module prbs_stream_gen
  import prbs_pkg::*;
#(
  parameter int unsigned           LFSR_WIDTH     = 8,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY      = LFSR_WIDTH'(PRBS_DEFAULT_POLY),
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED      = LFSR_WIDTH'(1),
  parameter int unsigned           BITS_PER_CLOCK = 1,
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           FIFO_DEPTH     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        burst_start,
  input  logic [15:0]                 burst_len,
  output logic                        burst_busy,
  input  logic                        seed_load,
  input  logic [LFSR_WIDTH-1:0]       seed_value,
`ifdef PRBS_STREAM_ERR_INJECT_EN
  input  logic                        err_inject,
`endif
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);

  prbs_state_e               state_q;
  logic [15:0]               words_left_q;
  logic [LFSR_WIDTH-1:0]     lfsr_q;
  logic [DATA_WIDTH-1:0]     word_q;
  logic [BIT_CNT_W-1:0]      bit_cnt_q;

  logic [LFSR_WIDTH-1:0]     lfsr_c;
  logic [BITS_PER_CLOCK-1:0] chunk_c;
  logic                      step_bit;
  logic [DATA_WIDTH-1:0]     word_c;
  logic                      word_done;
  logic                      advance;
  logic                      pop;
  logic                      push;
  logic [DATA_WIDTH-1:0]     push_data;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign pop     = m_ready && !fifo_empty;
  assign advance = ((state_q == ST_RUN) || (state_q == ST_BURST)) && (!fifo_full || pop);
  assign push    = advance && word_done;

  // BITS_PER_CLOCK LFSR steps and the packer word they would produce
  always_comb begin
    lfsr_c   = lfsr_q;
    chunk_c  = '0;
    step_bit = 1'b0;
    for (int i = 0; i < int'(BITS_PER_CLOCK); i++) begin
      lfsr_c     = LFSR_WIDTH'(lfsr_step(LFSR_MAX_W'(lfsr_c), LFSR_MAX_W'(LFSR_POLY), step_bit));
      chunk_c[i] = step_bit;
    end
    word_c    = word_q | (DATA_WIDTH'(chunk_c) << bit_cnt_q);
    word_done = (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - BITS_PER_CLOCK));
  end

`ifdef PRBS_STREAM_ERR_INJECT_EN
  logic inj_pending_q;

  // Sticky injection request, consumed by the next FIFO write
  always_ff @(posedge clk) begin
    if (reset) begin
      inj_pending_q <= 1'b0;
    end else if (push && inj_pending_q) begin
      inj_pending_q <= 1'b0;
    end else if (err_inject) begin
      inj_pending_q <= 1'b1;
    end
  end

  assign push_data = word_c ^ DATA_WIDTH'(inj_pending_q);
`else
  assign push_data = word_c;
`endif

  // Mode FSM: free-run, counted burst, and the burst_busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      burst_busy   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (burst_start && (burst_len != '0)) begin
            state_q      <= ST_BURST;
            words_left_q <= burst_len;
            burst_busy   <= 1'b1;
          end else if (enable) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state_q <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (push) begin
            words_left_q <= words_left_q - 16'd1;
            if (words_left_q == 16'd1) begin
              state_q    <= ST_IDLE;
              burst_busy <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          burst_busy <= 1'b0;
        end
      endcase
    end
  end

  // LFSR state and packer; reseed only while idle, partial words survive pauses
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q    <= LFSR_SEED;
      word_q    <= '0;
      bit_cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (seed_load) begin
        lfsr_q    <= (seed_value == '0) ? LFSR_SEED : seed_value;
        word_q    <= '0;
        bit_cnt_q <= '0;
      end
    end else if (advance) begin
      lfsr_q <= lfsr_c;
      if (word_done) begin
        word_q    <= '0;
        bit_cnt_q <= '0;
      end else begin
        word_q    <= word_c;
        bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(BITS_PER_CLOCK);
      end
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (m_data),
    .valid     (m_valid),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_prbs_stream_gen.sv
// Directed bench for prbs_stream_gen with default parameters.
module tb_prbs_stream_gen;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        burst_start;
  logic [15:0] burst_len;
  logic        burst_busy;
  logic        seed_load;
  logic [7:0]  seed_value;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  fifo_level;
`ifdef PRBS_STREAM_ERR_INJECT_EN
  logic        err_inject;
`endif

  int n_cmp;
  int n_err;
  logic [7:0] mdl_s;

  prbs_stream_gen dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .burst_busy  (burst_busy),
    .seed_load   (seed_load),
    .seed_value  (seed_value),
`ifdef PRBS_STREAM_ERR_INJECT_EN
    .err_inject  (err_inject),
`endif
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .fifo_level  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Golden 8-bit Galois LFSR (mask 0xB8), eight bits per word LSB-first
  task automatic mdl_next(output logic [7:0] w);
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[i]  = mdl_s[0];
      mdl_s = mdl_s[0] ? ((mdl_s >> 1) ^ 8'hB8) : (mdl_s >> 1);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    burst_start = 1'b0;
    burst_len   = 16'd0;
    seed_load   = 1'b0;
    seed_value  = 8'd0;
`ifdef PRBS_STREAM_ERR_INJECT_EN
    err_inject  = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Tick until m_valid, bounded; the bound expiring shows up as a failed check
  task automatic wait_valid(input string tag);
    int c;
    c = 0;
    do begin
      tick();
      c++;
    end while (!m_valid && c < 100);
    chk(tag, 32'(m_valid), 32'd1);
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] steady [4];
    logic [7:0] bexp [3];
    int         nwords;
    int         got;

    n_cmp   = 0;
    n_err   = 0;
    m_ready = 1'b0;
    do_reset();

    // Reset state
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data",  32'(m_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_busy",  32'(burst_busy), 32'd0);

    // Free run: first word 8 cycles after entering RUN, then one per 8 cycles
    m_ready = 1'b1;
    enable  = 1'b1;
    repeat (8) tick();
    chk("lat_before", 32'(m_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(m_valid), 32'd1);
    chk("word1", 32'(m_data), 32'h71);
    chk("word1_level", 32'(fifo_level), 32'd1);
    steady[0] = 8'hA4; steady[1] = 8'h03; steady[2] = 8'h93; steady[3] = 8'hEC;
    for (int k = 0; k < 4; k++) begin
      repeat (7) tick();
      chk("steady_gap", 32'(m_valid), 32'd0);
      tick();
      chk("steady_valid", 32'(m_valid), 32'd1);
      chk("steady_word", 32'(m_data), 32'(steady[k]));
    end

    // Backpressure: fill, hold stable, then drain against the golden model
    do_reset();
    m_ready = 1'b0;
    enable  = 1'b1;
    repeat (100) tick();
    chk("bp_level", 32'(fifo_level), 32'd8);
    chk("bp_valid", 32'(m_valid), 32'd1);
    chk("bp_head", 32'(m_data), 32'h71);
    repeat (5) tick();
    chk("bp_hold", 32'(m_data), 32'h71);
    mdl_s   = 8'h01;
    m_ready = 1'b1;
    got     = 0;
    for (int c = 0; c < 400 && got < 20; c++) begin
      if (m_valid) begin
        mdl_next(w);
        chk("bp_word", 32'(m_data), 32'(w));
        got++;
      end
      tick();
    end
    chk("bp_count", 32'(got), 32'd20);

    // Counted burst of 3 with a mid-burst enable toggle and ignored burst_start
    do_reset();
    m_ready     = 1'b1;
    burst_len   = 16'd3;
    burst_start = 1'b1;
    bexp[0] = 8'h71; bexp[1] = 8'hA4; bexp[2] = 8'h03;
    nwords  = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1)  chk("burst_busy_start", 32'(burst_busy), 32'd1);
      if (c == 24) chk("burst_busy_last",  32'(burst_busy), 32'd1);
      if (c == 25) chk("burst_busy_clear", 32'(burst_busy), 32'd0);
      if (m_valid) begin
        if (nwords < 3) chk("burst_word", 32'(m_data), 32'(bexp[nwords]));
        nwords++;
      end
      if (c == 1)  burst_start = 1'b0;
      if (c == 5)  enable = 1'b1;
      if (c == 10) begin burst_start = 1'b1; burst_len = 16'd5; end
      if (c == 11) burst_start = 1'b0;
      if (c == 15) enable = 1'b0;
    end
    chk("burst_count", 32'(nwords), 32'd3);

    // burst_len of zero is ignored
    do_reset();
    m_ready     = 1'b1;
    burst_len   = 16'd0;
    burst_start = 1'b1;
    tick();
    burst_start = 1'b0;
    repeat (20) tick();
    chk("zlen_busy",  32'(burst_busy), 32'd0);
    chk("zlen_valid", 32'(m_valid), 32'd0);

    // Partial word held across a pause
    do_reset();
    m_ready = 1'b1;
    enable  = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    repeat (11) tick();
    chk("pause_novalid", 32'(m_valid), 32'd0);
    enable = 1'b1;
    wait_valid("pause_wait");
    chk("pause_word", 32'(m_data), 32'h71);

    // Reseed in IDLE, zero-seed guard, reseed ignored while running
    do_reset();
    m_ready    = 1'b1;
    seed_load  = 1'b1;
    seed_value = 8'h64;
    tick();
    seed_load = 1'b0;
    enable    = 1'b1;
    wait_valid("seed_wait1");
    chk("seed_word", 32'(m_data), 32'hA4);
    enable = 1'b0;
    repeat (4) tick();
    seed_load  = 1'b1;
    seed_value = 8'h00;
    tick();
    seed_load = 1'b0;
    enable    = 1'b1;
    wait_valid("seed_wait2");
    chk("seed_zero_word", 32'(m_data), 32'h71);
    seed_load  = 1'b1;
    seed_value = 8'h55;
    tick();
    seed_load = 1'b0;
    wait_valid("seed_wait3");
    chk("seed_run_ignored", 32'(m_data), 32'hA4);
    enable = 1'b0;

`ifdef PRBS_STREAM_ERR_INJECT_EN
    // Error injection flips bit 0 of exactly one word
    do_reset();
    m_ready    = 1'b1;
    err_inject = 1'b1;
    tick();
    err_inject = 1'b0;
    enable     = 1'b1;
    wait_valid("inj_wait1");
    chk("inj_word1", 32'(m_data), 32'h70);
    wait_valid("inj_wait2");
    chk("inj_word2", 32'(m_data), 32'hA4);
    enable = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
